ofdm_demodulator: RTL and testbench

// - Receive-side counterpart of the OFDM modulator.
// - Accepts one 8-point OFDM symbol as 8 serial complex time-domain samples.
// - Runs a forward 8-point radix-2 DIT FFT on a single time-shared butterfly.
// - Slices each bin with a hard 16-QAM Gray demapper and emits one packed 32-bit data word per symbol.
// - Sits between channel/sample input and the data sink; ready/valid on both sides.

---
 rtl/ofdm_pkg.sv | 47 ++++
 rtl/ofdm_butterfly.sv | 48 ++++
 rtl/ofdm_demodulator.sv | 163 ++++++++++++++++
 tb/tb_ofdm_demodulator.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ofdm_pkg.sv
// Shared constants for the 8-point OFDM receive path: sizes, 16-QAM Gray levels,
// Q1.14 twiddle ROM, bit-reversal helper and the demodulator state type.
package ofdm_pkg;

    localparam int N_PTS    = 8;
    localparam int QAM_BITS = 4;
    localparam int TW_FRAC  = 14;

    localparam logic [1:0] LVL_M3 = 2'b00;
    localparam logic [1:0] LVL_M1 = 2'b01;
    localparam logic [1:0] LVL_P1 = 2'b11;
    localparam logic [1:0] LVL_P3 = 2'b10;

    localparam logic signed [15:0] TW_ONE  = 16'sd16384;
    localparam logic signed [15:0] TW_HALF = 16'sd11585;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        COMPUTE = 2'd1,
        SLICE   = 2'd2,
        OUTPUT  = 2'd3
    } state_t;

    function automatic logic [2:0] bitrev3(input logic [2:0] v);
        return {v[0], v[1], v[2]};
    endfunction

    // W8^k = exp(-j*2*pi*k/8), k = 0..3
    function automatic logic signed [15:0] tw_re(input logic [1:0] k);
        case (k)
            2'd0:    return TW_ONE;
            2'd1:    return TW_HALF;
            2'd2:    return 16'sd0;
            default: return -TW_HALF;
        endcase
    endfunction

    function automatic logic signed [15:0] tw_im(input logic [1:0] k);
        case (k)
            2'd0:    return 16'sd0;
            2'd1:    return -TW_HALF;
            2'd2:    return -TW_ONE;
            default: return -TW_HALF;
        endcase
    endfunction

endpackage

// File: rtl/ofdm_butterfly.sv
// Combinational radix-2 DIT butterfly: returns a + b*W and a - b*W, with the
// complex product rounded half-up back to the data width.
module ofdm_butterfly #(
    parameter int IW   = 19,
    parameter int TW_W = 16
) (
    input  logic signed [IW-1:0]   a_re_i,
    input  logic signed [IW-1:0]   a_im_i,
    input  logic signed [IW-1:0]   b_re_i,
    input  logic signed [IW-1:0]   b_im_i,
    input  logic signed [TW_W-1:0] w_re_i,
    input  logic signed [TW_W-1:0] w_im_i,
    output logic signed [IW-1:0]   x_re_o,
    output logic signed [IW-1:0]   x_im_o,
    output logic signed [IW-1:0]   y_re_o,
    output logic signed [IW-1:0]   y_im_o
);

    localparam int TW_FRAC = TW_W - 2;
    localparam int PW      = IW + TW_W + 1;
    localparam logic signed [PW-1:0] RND = PW'(2 ** (TW_FRAC - 1));

    logic signed [PW-1:0] b_re_x;
    logic signed [PW-1:0] b_im_x;
    logic signed [PW-1:0] w_re_x;
    logic signed [PW-1:0] w_im_x;
    logic signed [PW-1:0] p_re;
    logic signed [PW-1:0] p_im;
    logic signed [IW-1:0] bw_re;
    logic signed [IW-1:0] bw_im;

    assign b_re_x = PW'(b_re_i);
    assign b_im_x = PW'(b_im_i);
    assign w_re_x = PW'(w_re_i);
    assign w_im_x = PW'(w_im_i);

    // One rounding per output component, applied to the full complex sum
    assign p_re  = b_re_x * w_re_x - b_im_x * w_im_x + RND;
    assign p_im  = b_re_x * w_im_x + b_im_x * w_re_x + RND;
    assign bw_re = IW'(p_re >>> TW_FRAC);
    assign bw_im = IW'(p_im >>> TW_FRAC);

    assign x_re_o = a_re_i + bw_re;
    assign x_im_o = a_im_i + bw_im;
    assign y_re_o = a_re_i - bw_re;
    assign y_im_o = a_im_i - bw_im;

endmodule

// File: rtl/ofdm_demodulator.sv
// 8-point OFDM receiver: serial sample collection, in-place FFT on one shared
// butterfly, hard 16-QAM Gray slicing into a 32-bit word with ready/valid handshakes.
module ofdm_demodulator
    import ofdm_pkg::*;
#(
    parameter int IN_W = 16,
    parameter int AMP  = 256,
    parameter int TW_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic signed [IN_W-1:0] in_re,
    input  logic signed [IN_W-1:0] in_im,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            data_out
);

    localparam int IW = IN_W + 3;
    localparam logic signed [IW-1:0] THR_P = IW'(2 * AMP);
    localparam logic signed [IW-1:0] THR_N = IW'(-2 * AMP);
    localparam logic signed [IW-1:0] ZERO  = '0;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] data_q, data_d;

    logic signed [IW-1:0] buf_re_q [N_PTS];
    logic signed [IW-1:0] buf_im_q [N_PTS];

    logic [2:0]           a_idx, b_idx;
    logic [1:0]           tw_idx;
    logic signed [IW-1:0] x_re, x_im, y_re, y_im;
    logic [31:0]          slice_word;

    function automatic logic [1:0] slice_axis(input logic signed [IW-1:0] v);
        if (v >= THR_P)      return LVL_P3;
        else if (v >= ZERO)  return LVL_P1;
        else if (v >= THR_N) return LVL_M1;
        else                 return LVL_M3;
    endfunction

    // During COMPUTE, cnt_q[3:2] is the stage (span 1/2/4) and cnt_q[1:0] the butterfly
    always_comb begin
        a_idx  = '0;
        b_idx  = '0;
        tw_idx = '0;
        case (cnt_q[3:2])
            2'd0: begin
                a_idx  = {cnt_q[1:0], 1'b0};
                b_idx  = {cnt_q[1:0], 1'b1};
                tw_idx = 2'd0;
            end
            2'd1: begin
                a_idx  = {cnt_q[1], 1'b0, cnt_q[0]};
                b_idx  = {cnt_q[1], 1'b1, cnt_q[0]};
                tw_idx = {cnt_q[0], 1'b0};
            end
            default: begin
                a_idx  = {1'b0, cnt_q[1:0]};
                b_idx  = {1'b1, cnt_q[1:0]};
                tw_idx = cnt_q[1:0];
            end
        endcase
    end

    ofdm_butterfly #(
        .IW   (IW),
        .TW_W (TW_W)
    ) u_bfly (
        .a_re_i (buf_re_q[a_idx]),
        .a_im_i (buf_im_q[a_idx]),
        .b_re_i (buf_re_q[b_idx]),
        .b_im_i (buf_im_q[b_idx]),
        .w_re_i (TW_W'(tw_re(tw_idx))),
        .w_im_i (TW_W'(tw_im(tw_idx))),
        .x_re_o (x_re),
        .x_im_o (x_im),
        .y_re_o (y_re),
        .y_im_o (y_im)
    );

    always_comb begin
        slice_word = '0;
        for (int k = 0; k < N_PTS; k++) begin
            slice_word[31 - QAM_BITS*k -: QAM_BITS] = {slice_axis(buf_re_q[k]), slice_axis(buf_im_q[k])};
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        data_d      = data_q;
        case (state_q)
            COLLECT: begin
                if (in_valid) begin
                    if (cnt_q == 4'd7) begin
                        cnt_d   = '0;
                        state_d = COMPUTE;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            COMPUTE: begin
                if (cnt_q == 4'd11) begin
                    cnt_d   = '0;
                    state_d = SLICE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            SLICE: begin
                data_d      = slice_word;
                out_valid_d = 1'b1;
                state_d     = OUTPUT;
            end
            OUTPUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= COLLECT;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            data_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            data_q      <= data_d;
        end
    end

    // Sample buffer is data only: no reset, samples land bit-reversed for in-place DIT
    always_ff @(posedge clk) begin
        if (state_q == COLLECT && in_valid) begin
            buf_re_q[bitrev3(cnt_q[2:0])] <= IW'(in_re);
            buf_im_q[bitrev3(cnt_q[2:0])] <= IW'(in_im);
        end else if (state_q == COMPUTE) begin
            buf_re_q[a_idx] <= x_re;
            buf_im_q[a_idx] <= x_im;
            buf_re_q[b_idx] <= y_re;
            buf_im_q[b_idx] <= y_im;
        end
    end

    assign in_ready  = (state_q == COLLECT);
    assign out_valid = out_valid_q;
    assign data_out  = data_q;

endmodule

// File: tb/tb_ofdm_demodulator.sv
// Self-checking bench for ofdm_demodulator: real-valued DFT/IDFT reference model,
// directed impulse/DC/tie/backpressure/reset cases and randomized round trips.
module tb_ofdm_demodulator;

    localparam int  IN_W = 16;
    localparam int  AMP  = 256;
    localparam real PI   = 3.14159265358979323846;

    logic                   clk       = 1'b0;
    logic                   reset     = 1'b1;
    logic                   in_valid  = 1'b0;
    logic                   in_ready;
    logic signed [IN_W-1:0] in_re     = '0;
    logic signed [IN_W-1:0] in_im     = '0;
    logic                   out_valid;
    logic                   out_ready = 1'b1;
    logic [31:0]            data_out;

    ofdm_demodulator #(
        .IN_W (IN_W),
        .AMP  (AMP),
        .TW_W (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_re     (in_re),
        .in_im     (in_im),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_pass  = 0;
    int          n_total = 0;
    logic [31:0] exp_q[$];
    int          acc_q[$];
    int          sym_re[8];
    int          sym_im[8];
    int          bp_mode  = 0;
    bit          rnd_gaps = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    endtask

    function automatic int rnd(input real x);
        if (x >= 0.0) return $rtoi(x + 0.5);
        return -$rtoi(-x + 0.5);
    endfunction

    function automatic logic [1:0] decide(input int v);
        if (v >= 2*AMP)  return 2'b10;
        if (v >= 0)      return 2'b11;
        if (v >= -2*AMP) return 2'b01;
        return 2'b00;
    endfunction

    function automatic int level(input logic [1:0] b);
        case (b)
            2'b00:   return -3;
            2'b01:   return -1;
            2'b11:   return 1;
            default: return 3;
        endcase
    endfunction

    // Direct forward DFT of sym_re/sym_im, rounded to integers, then sliced per axis
    function automatic logic [31:0] model_demod();
        logic [31:0] w;
        real xr, xi, th;
        w = '0;
        for (int k = 0; k < 8; k++) begin
            xr = 0.0;
            xi = 0.0;
            for (int n = 0; n < 8; n++) begin
                th = 2.0 * PI * real'(k * n) / 8.0;
                xr = xr + real'(sym_re[n]) * $cos(th) + real'(sym_im[n]) * $sin(th);
                xi = xi + real'(sym_im[n]) * $cos(th) - real'(sym_re[n]) * $sin(th);
            end
            w[31 - 4*k -: 4] = {decide(rnd(xr)), decide(rnd(xi))};
        end
        return w;
    endfunction

    // Transmitter side: Gray levels scaled by AMP, inverse DFT with 1/8, rounded
    task automatic modulate(input logic [31:0] word);
        int  lr[8];
        int  li[8];
        real xr, xi, th;
        for (int k = 0; k < 8; k++) begin
            lr[k] = level(word[31 - 4*k -: 2]) * AMP;
            li[k] = level(word[29 - 4*k -: 2]) * AMP;
        end
        for (int n = 0; n < 8; n++) begin
            xr = 0.0;
            xi = 0.0;
            for (int k = 0; k < 8; k++) begin
                th = 2.0 * PI * real'(k * n) / 8.0;
                xr = xr + real'(lr[k]) * $cos(th) - real'(li[k]) * $sin(th);
                xi = xi + real'(lr[k]) * $sin(th) + real'(li[k]) * $cos(th);
            end
            sym_re[n] = rnd(xr / 8.0);
            sym_im[n] = rnd(xi / 8.0);
        end
    endtask

    task automatic set_const(input int re, input int im);
        for (int n = 0; n < 8; n++) begin
            sym_re[n] = re;
            sym_im[n] = im;
        end
    endtask

    task automatic set_impulse(input int re0);
        set_const(0, 0);
        sym_re[0] = re0;
    endtask

    // Called and returns at posedge+1
    task automatic send_symbol(input logic [31:0] expw, input bit track);
        bit acc;
        int budget;
        int acc_c;
        acc_c = 0;
        for (int n = 0; n < 8; n++) begin
            acc    = 1'b0;
            budget = 0;
            if (rnd_gaps && $urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(1, 2)) @(posedge clk);
                #1;
            end
            in_valid = 1'b1;
            in_re    = 16'(sym_re[n]);
            in_im    = 16'(sym_im[n]);
            while (!acc) begin
                @(negedge clk);
                acc   = (in_ready === 1'b1);
                acc_c = cyc;
                @(posedge clk);
                #1;
                budget++;
                if (!acc && budget > 300) begin
                    n_total++;
                    $display("FAIL in_ready_timeout: sample %0d not accepted within 300 cycles", n);
                    in_valid = 1'b0;
                    return;
                end
            end
        end
        in_valid = 1'b0;
        if (track) begin
            exp_q.push_back(expw);
            acc_q.push_back(acc_c);
        end
    endtask

    task automatic drain();
        int b;
        b = 0;
        while (exp_q.size() != 0 && b < 3000) begin
            @(posedge clk);
            #1;
            b++;
        end
        chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs();
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_data_out",  data_out,       32'd0);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (bp_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Output monitor: ordering, latency, hold-under-backpressure and handshake follow-up
    bit          prev_ov = 1'b0;
    bit          prev_hs = 1'b0;
    bit          held_v  = 1'b0;
    logic [31:0] held    = '0;

    always @(negedge clk) begin
        if (!reset) begin
            prev_ov = 1'b0;
            prev_hs = 1'b0;
            held_v  = 1'b0;
        end else begin
            if (prev_hs) chk("in_ready_after_handshake", 32'(in_ready), 32'd1);
            if (held_v) begin
                chk("out_valid_held", 32'(out_valid), 32'd1);
                chk("data_out_held", data_out, held);
            end
            if (out_valid) begin
                chk("in_ready_low_during_output", 32'(in_ready), 32'd0);
                if (!prev_ov) begin
                    chk("out_valid_expected", (exp_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
                    if (acc_q.size() > 0) chk("latency", 32'(cyc - acc_q[0]), 32'd14);
                end
            end
            prev_hs = out_valid && out_ready;
            if (prev_hs) begin
                if (exp_q.size() > 0) begin
                    chk("data_out", data_out, exp_q.pop_front());
                    void'(acc_q.pop_front());
                end
                held_v = 1'b0;
            end else if (out_valid) begin
                held   = data_out;
                held_v = 1'b1;
            end else begin
                held_v = 1'b0;
            end
            prev_ov = out_valid;
        end
    end

    initial begin
        int          b;
        logic [31:0] w;
        logic [31:0] fixed_words [3];
        fixed_words[0] = 32'h0000_0000;
        fixed_words[1] = 32'hFFFF_FFFF;
        fixed_words[2] = 32'h1234_5678;

        #2 reset = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs();
        @(posedge clk);
        #1 reset = 1'b1;

        // Directed symbols with hand-derived words pinning the model
        set_impulse(768);
        chk("model_impulse", model_demod(), 32'hBBBB_BBBB);
        send_symbol(32'hBBBB_BBBB, 1'b1);

        set_const(256, -256);
        chk("model_dc", model_demod(), 32'h8FFF_FFFF);
        send_symbol(32'h8FFF_FFFF, 1'b1);

        set_const(64, -64);
        chk("model_ties", model_demod(), 32'h9FFF_FFFF);
        send_symbol(32'h9FFF_FFFF, 1'b1);

        for (int i = 0; i < 3; i++) begin
            modulate(fixed_words[i]);
            chk("model_round_trip_fixed", model_demod(), fixed_words[i]);
            send_symbol(model_demod(), 1'b1);
        end
        drain();

        // Backpressure: output held for 20 cycles while extra input is offered
        bp_mode = 2;
        set_const(256, -256);
        send_symbol(model_demod(), 1'b1);
        b = 0;
        while (out_valid !== 1'b1 && b < 100) begin
            @(posedge clk);
            #1;
            b++;
        end
        chk("bp_out_valid_seen", 32'(out_valid), 32'd1);
        in_valid = 1'b1;
        in_re    = 16'sd1234;
        in_im    = -16'sd77;
        repeat (20) @(posedge clk);
        #1;
        in_valid = 1'b0;
        bp_mode  = 0;
        drain();
        set_impulse(768);
        send_symbol(32'hBBBB_BBBB, 1'b1);
        drain();

        // Reset during COMPUTE discards the symbol in flight
        set_const(256, -256);
        send_symbol(32'h0, 1'b0);
        repeat (5) @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_reset_outputs();
        end
        @(posedge clk);
        #1 reset = 1'b1;
        set_impulse(768);
        send_symbol(32'hBBBB_BBBB, 1'b1);
        drain();
        repeat (40) @(posedge clk);
        #1;

        // Randomized round trips with random input gaps and output backpressure
        bp_mode  = 1;
        rnd_gaps = 1'b1;
        for (int i = 0; i < 512; i++) begin
            w = $urandom;
            modulate(w);
            chk("model_round_trip_rand", model_demod(), w);
            send_symbol(w, 1'b1);
        end
        drain();
        bp_mode  = 0;
        rnd_gaps = 1'b0;
        repeat (5) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
